// File: rtl/rv32_mem_pkg.sv
// rv32_mem_pkg: load/store encodings, request record and alignment helpers for the MEM stage.
package rv32_mem_pkg;
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;
   localparam int RD_EN_BIT = 3;
   localparam int WR_EN_BIT = 2;
   typedef enum logic [1:0] {IDLE, ACCESS, ERR} state_t;
   typedef struct packed {
      logic [3:0]  ren;
      logic [2:0]  wen;
      logic [31:0] addr;
      logic [31:0] data;
      logic [4:0]  rd;
      logic        we;
   } mem_req_t;
   function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] a);
      return (sz == SZ_H && a[0]) || (sz == SZ_W && a != 2'b00);
   endfunction
   function automatic logic [31:0] store_align(input logic [1:0] sz, input logic [31:0] d);
      return sz == SZ_B ? {4{d[7:0]}} : sz == SZ_H ? {2{d[15:0]}} : d;
   endfunction
endpackage

// File: rtl/load_extend.sv
// load_extend: selects the addressed byte/half of a cache word and sign- or zero-extends it.
module load_extend
   import rv32_mem_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  offset,
   input  logic [31:0] word,
   output logic [31:0] result
);
   logic [7:0]  b;
   logic [15:0] h;
   assign b = word[{offset, 3'b000} +: 8];
   assign h = word[{offset[1], 4'b0000} +: 16];
   assign result = funct3 == F3_LW  ? word :
                   funct3 == F3_LB  ? {{24{b[7]}}, b} :
                   funct3 == F3_LBU ? {24'b0, b} :
                   funct3 == F3_LH  ? {{16{h[15]}}, h} :
                   funct3 == F3_LHU ? {16'b0, h} : word;
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: RV32 MEM stage - data-cache handshake, store alignment, load extension, MEM/WB register.
module mem_access_unit
   import rv32_mem_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int CNT_W = 32
)(
   input  logic             CLK,
   input  logic             RESET,
   input  logic             EX_VALID,
   input  logic [31:0]      EX_ALU_OUT,
   input  logic [31:0]      EX_STORE_DATA,
   input  logic [4:0]       EX_RD,
   input  logic             EX_REG_WRITE_EN,
   input  logic [3:0]       EX_MEM_READ,
   input  logic [2:0]       EX_MEM_WRITE,
   output logic [3:0]       memReadEn,
   output logic [2:0]       memWriteEn,
   output logic [31:0]      DATA_CACHE_ADDR,
   output logic [31:0]      DATA_CACHE_DATA,
   input  logic [31:0]      DATA_CACHE_READ_DATA,
   input  logic             DATA_CACHE_BUSY_WAIT,
   output logic             STALL,
   output logic [31:0]      WB_RESULT,
   output logic [4:0]       WB_RD,
   output logic             WB_REG_WRITE_EN,
   output logic             MISALIGN,
   output logic             BUS_ERR,
   output logic [CNT_W-1:0] STALL_COUNT
);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   state_t        state;
   mem_req_t      req_d, req_q, cur;
   logic [TW-1:0] wait_cnt;
   logic          rd_req, wr_req, mis, issue, act, done;
   logic [31:0]   load_data;
   assign rd_req = EX_MEM_READ[RD_EN_BIT];
   assign wr_req = EX_MEM_WRITE[WR_EN_BIT] & ~rd_req;
   assign mis = EX_VALID & (rd_req ? misaligned(EX_MEM_READ[1:0], EX_ALU_OUT[1:0])
                                   : wr_req & misaligned(EX_MEM_WRITE[1:0], EX_ALU_OUT[1:0]));
   assign issue = EX_VALID & (rd_req | wr_req) & ~mis;
   assign req_d = '{ren:  rd_req ? EX_MEM_READ : 4'b0,
                    wen:  wr_req ? EX_MEM_WRITE : 3'b0,
                    addr: EX_ALU_OUT,
                    data: store_align(EX_MEM_WRITE[1:0], EX_STORE_DATA),
                    rd:   EX_RD,
                    we:   EX_VALID & EX_REG_WRITE_EN & ~mis};
   // The captured request keeps the cache interface stable for the whole miss.
   assign cur = state == ACCESS ? req_q : req_d;
   assign act = RESET & (state == ACCESS || (state == IDLE && issue));
   assign STALL = act & DATA_CACHE_BUSY_WAIT;
   assign done = (state == IDLE || state == ACCESS) & ~STALL;
   assign memReadEn = act ? cur.ren : 4'b0;
   assign memWriteEn = act ? cur.wen : 3'b0;
   assign DATA_CACHE_ADDR = act ? cur.addr : 32'b0;
   assign DATA_CACHE_DATA = act && cur.wen[WR_EN_BIT] ? cur.data : 32'b0;
   load_extend u_ext (
      .funct3(cur.ren[2:0]),
      .offset(cur.addr[1:0]),
      .word  (DATA_CACHE_READ_DATA),
      .result(load_data)
   );
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state           <= IDLE;
         req_q           <= '0;
         wait_cnt        <= '0;
         WB_RESULT       <= '0;
         WB_RD           <= '0;
         WB_REG_WRITE_EN <= 1'b0;
         MISALIGN        <= 1'b0;
         BUS_ERR         <= 1'b0;
         STALL_COUNT     <= '0;
      end else begin
         MISALIGN <= state == IDLE && mis;
         WB_REG_WRITE_EN <= done & cur.we;
         if (STALL) STALL_COUNT <= STALL_COUNT + CNT_W'(1);
         if (done) begin
            WB_RESULT <= cur.ren[RD_EN_BIT] ? load_data : cur.addr;
            WB_RD     <= cur.rd;
         end
         case (state)
            IDLE: if (STALL) begin
               req_q    <= req_d;
               wait_cnt <= TW'(1);
               state    <= ACCESS;
            end
            ACCESS: if (!DATA_CACHE_BUSY_WAIT) state <= IDLE;
            else if (wait_cnt >= TW'(TIMEOUT_CYCLES - 1)) begin
               state   <= ERR;
               BUS_ERR <= 1'b1;
            end else wait_cnt <= wait_cnt + TW'(1);
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed vector table, hand-written corner sequences and randomized ops vs a behavioural model.
module tb_mem_access_unit;
   logic        CLK = 1'b0;
   logic        RESET;
   logic        EX_VALID, EX_REG_WRITE_EN, DATA_CACHE_BUSY_WAIT;
   logic [31:0] EX_ALU_OUT, EX_STORE_DATA, DATA_CACHE_READ_DATA;
   logic [4:0]  EX_RD;
   logic [3:0]  EX_MEM_READ;
   logic [2:0]  EX_MEM_WRITE;
   logic [3:0]  memReadEn;
   logic [2:0]  memWriteEn;
   logic [31:0] DATA_CACHE_ADDR, DATA_CACHE_DATA, WB_RESULT, STALL_COUNT;
   logic [4:0]  WB_RD;
   logic        STALL, WB_REG_WRITE_EN, MISALIGN, BUS_ERR;

   int n_vec = 0;
   int n_miss = 0;
   int exp_cnt = 0;

   typedef struct {
      logic        valid;
      logic [31:0] alu;
      logic [31:0] sdata;
      logic [4:0]  rd;
      logic        we;
      logic [3:0]  mr;
      logic [2:0]  mw;
      logic [31:0] rdata;
      int          busy;
      logic [3:0]  e_ren;
      logic [2:0]  e_wen;
      logic [31:0] e_data;
      logic [31:0] e_res;
      logic        chk;
      logic        e_we;
      logic        e_mis;
   } vec_t;

   vec_t tbl [14];
   logic [2:0] f3s [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

   mem_access_unit #(.TIMEOUT_CYCLES(8), .CNT_W(32)) dut (
      .CLK(CLK), .RESET(RESET), .EX_VALID(EX_VALID), .EX_ALU_OUT(EX_ALU_OUT),
      .EX_STORE_DATA(EX_STORE_DATA), .EX_RD(EX_RD), .EX_REG_WRITE_EN(EX_REG_WRITE_EN),
      .EX_MEM_READ(EX_MEM_READ), .EX_MEM_WRITE(EX_MEM_WRITE), .memReadEn(memReadEn),
      .memWriteEn(memWriteEn), .DATA_CACHE_ADDR(DATA_CACHE_ADDR), .DATA_CACHE_DATA(DATA_CACHE_DATA),
      .DATA_CACHE_READ_DATA(DATA_CACHE_READ_DATA), .DATA_CACHE_BUSY_WAIT(DATA_CACHE_BUSY_WAIT),
      .STALL(STALL), .WB_RESULT(WB_RESULT), .WB_RD(WB_RD), .WB_REG_WRITE_EN(WB_REG_WRITE_EN),
      .MISALIGN(MISALIGN), .BUS_ERR(BUS_ERR), .STALL_COUNT(STALL_COUNT)
   );

   always #5 CLK = ~CLK;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endfunction

   task automatic drive(input vec_t v);
      EX_VALID = v.valid;
      EX_ALU_OUT = v.alu;
      EX_STORE_DATA = v.sdata;
      EX_RD = v.rd;
      EX_REG_WRITE_EN = v.we;
      EX_MEM_READ = v.mr;
      EX_MEM_WRITE = v.mw;
      DATA_CACHE_READ_DATA = v.rdata;
      DATA_CACHE_BUSY_WAIT = v.busy > 0;
   endtask

   task automatic drive_idle();
      EX_VALID = 1'b0;
      EX_ALU_OUT = '0;
      EX_STORE_DATA = '0;
      EX_RD = '0;
      EX_REG_WRITE_EN = 1'b0;
      EX_MEM_READ = '0;
      EX_MEM_WRITE = '0;
      DATA_CACHE_READ_DATA = '0;
      DATA_CACHE_BUSY_WAIT = 1'b0;
   endtask

   // Behavioural model: access width in bytes, alignment by modulo, lanes by shifting.
   task automatic fill_expect(input vec_t i, output vec_t o);
      int a, sz;
      logic isr, isw, bad, iss;
      longint w, d, m;
      o = i;
      isr = i.mr[3];
      isw = i.mw[2] && !isr;
      sz = isr ? (1 << i.mr[1:0]) : (1 << i.mw[1:0]);
      a = int'(i.alu[1:0]);
      bad = i.valid && (isr || isw) && (a % sz != 0);
      iss = i.valid && (isr || isw) && !bad;
      o.e_ren = iss && isr ? i.mr : 4'b0;
      o.e_wen = iss && isw ? i.mw : 3'b0;
      m = (longint'(1) << (8 * sz)) - 1;
      d = longint'(i.sdata) & m;
      w = 0;
      for (int k = 0; k < 4; k += sz) w = w | (d << (8 * k));
      o.e_data = w[31:0];
      w = (longint'(i.rdata) >> (8 * a)) & m;
      if (!i.mr[2] && sz < 4 && w >= (m + 1) / 2) w = w - (m + 1);
      o.e_res = isr ? w[31:0] : i.alu;
      o.chk = i.valid && !bad && !isw;
      o.e_we = i.valid && i.we && !bad;
      o.e_mis = bad;
   endtask

   task automatic run_op(input vec_t v);
      int n;
      logic iss;
      iss = v.e_ren[3] | v.e_wen[2];
      n = iss ? v.busy : 0;
      @(negedge CLK);
      drive(v);
      for (int c = 0; c <= n; c++) begin
         if (c > 0) begin
            @(negedge CLK);
            if (c == n) DATA_CACHE_BUSY_WAIT = 1'b0;
         end
         #3;
         check("memReadEn", 32'(memReadEn), 32'(v.e_ren));
         check("memWriteEn", 32'(memWriteEn), 32'(v.e_wen));
         check("STALL", 32'(STALL), 32'(c < n));
         if (iss) check("addr", DATA_CACHE_ADDR, v.alu);
         if (v.e_wen[2]) check("store_data", DATA_CACHE_DATA, v.e_data);
      end
      exp_cnt += n;
      @(posedge CLK);
      #1;
      check("WB_REG_WRITE_EN", 32'(WB_REG_WRITE_EN), 32'(v.e_we));
      check("MISALIGN", 32'(MISALIGN), 32'(v.e_mis));
      check("STALL_COUNT", STALL_COUNT, 32'(exp_cnt));
      if (v.chk) begin
         check("WB_RESULT", WB_RESULT, v.e_res);
         check("WB_RD", 32'(WB_RD), 32'(v.rd));
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ren"}, 32'(memReadEn), 32'd0);
      check({tag, "_wen"}, 32'(memWriteEn), 32'd0);
      check({tag, "_addr"}, DATA_CACHE_ADDR, 32'd0);
      check({tag, "_stall"}, 32'(STALL), 32'd0);
      check({tag, "_wb_res"}, WB_RESULT, 32'd0);
      check({tag, "_wb_rd"}, 32'(WB_RD), 32'd0);
      check({tag, "_wb_we"}, 32'(WB_REG_WRITE_EN), 32'd0);
      check({tag, "_mis"}, 32'(MISALIGN), 32'd0);
      check({tag, "_buserr"}, 32'(BUS_ERR), 32'd0);
      check({tag, "_cnt"}, STALL_COUNT, 32'd0);
   endtask

   initial begin
      vec_t v, r;
      int kind;
      tbl[0]  = '{1'b1, 32'h100, 32'h0, 5'd1, 1'b1, 4'b1010, 3'b000, 32'hDEADBEEF, 0, 4'b1010, 3'b000, 32'h0, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0};
      tbl[1]  = '{1'b1, 32'h103, 32'h0, 5'd2, 1'b1, 4'b1000, 3'b000, 32'h80112233, 3, 4'b1000, 3'b000, 32'h0, 32'hFFFFFF80, 1'b1, 1'b1, 1'b0};
      tbl[2]  = '{1'b1, 32'h102, 32'h0, 5'd3, 1'b1, 4'b1101, 3'b000, 32'h80112233, 1, 4'b1101, 3'b000, 32'h0, 32'h00008011, 1'b1, 1'b1, 1'b0};
      tbl[3]  = '{1'b1, 32'h201, 32'h123456A5, 5'd0, 1'b0, 4'b0000, 3'b100, 32'h0, 0, 4'b0000, 3'b100, 32'hA5A5A5A5, 32'h0, 1'b0, 1'b0, 1'b0};
      tbl[4]  = '{1'b1, 32'h102, 32'h11223344, 5'd4, 1'b1, 4'b0000, 3'b110, 32'h0, 0, 4'b0000, 3'b000, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1};
      tbl[5]  = '{1'b1, 32'h12345678, 32'h0, 5'd7, 1'b1, 4'b0000, 3'b000, 32'h0, 2, 4'b0000, 3'b000, 32'h0, 32'h12345678, 1'b1, 1'b1, 1'b0};
      tbl[6]  = '{1'b0, 32'h100, 32'h0, 5'd8, 1'b1, 4'b1010, 3'b000, 32'h0, 0, 4'b0000, 3'b000, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0};
      tbl[7]  = '{1'b1, 32'h40, 32'h55555555, 5'd9, 1'b1, 4'b1010, 3'b110, 32'hCAFEF00D, 2, 4'b1010, 3'b000, 32'h0, 32'hCAFEF00D, 1'b1, 1'b1, 1'b0};
      tbl[8]  = '{1'b1, 32'h206, 32'h0, 5'd10, 1'b1, 4'b1001, 3'b000, 32'h9ABC1234, 0, 4'b1001, 3'b000, 32'h0, 32'hFFFF9ABC, 1'b1, 1'b1, 1'b0};
      tbl[9]  = '{1'b1, 32'h301, 32'h0, 5'd11, 1'b1, 4'b1100, 3'b000, 32'h1234F1FF, 1, 4'b1100, 3'b000, 32'h0, 32'h000000F1, 1'b1, 1'b1, 1'b0};
      tbl[10] = '{1'b1, 32'h402, 32'hFFFFBEEF, 5'd0, 1'b0, 4'b0000, 3'b101, 32'h0, 1, 4'b0000, 3'b101, 32'hBEEFBEEF, 32'h0, 1'b0, 1'b0, 1'b0};
      tbl[11] = '{1'b1, 32'h101, 32'h0, 5'd12, 1'b1, 4'b1001, 3'b000, 32'h0, 0, 4'b0000, 3'b000, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1};
      tbl[12] = '{1'b1, 32'h10A, 32'h0, 5'd12, 1'b1, 4'b1010, 3'b000, 32'h0, 1, 4'b0000, 3'b000, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1};
      tbl[13] = '{1'b1, 32'h500, 32'h01020304, 5'd0, 1'b0, 4'b0000, 3'b110, 32'h0, 4, 4'b0000, 3'b110, 32'h01020304, 32'h0, 1'b0, 1'b0, 1'b0};

      RESET = 1'b0;
      drive_idle();
      #12;
      check_reset_outputs("reset");
      @(negedge CLK);
      RESET = 1'b1;

      for (int i = 0; i < 14; i++) run_op(tbl[i]);

      // Timeout: cache never answers.
      @(negedge CLK);
      v = tbl[0];
      v.alu = 32'h600;
      v.busy = 1;
      drive(v);
      for (int c = 0; c < 8; c++) begin
         if (c > 0) @(negedge CLK);
         #3;
         check("to_stall", 32'(STALL), 32'd1);
         check("to_ren", 32'(memReadEn), 32'b1010);
         check("to_buserr_early", 32'(BUS_ERR), 32'd0);
      end
      exp_cnt += 8;
      @(negedge CLK);
      #3;
      check("err_stall", 32'(STALL), 32'd0);
      check("err_ren", 32'(memReadEn), 32'd0);
      check("err_buserr", 32'(BUS_ERR), 32'd1);
      check("err_cnt", STALL_COUNT, 32'(exp_cnt));
      check("err_wb_we", 32'(WB_REG_WRITE_EN), 32'd0);
      @(negedge CLK);
      drive_idle();
      #3;
      check("post_err_wb_we", 32'(WB_REG_WRITE_EN), 32'd0);
      check("buserr_sticky", 32'(BUS_ERR), 32'd1);
      check("post_err_ren", 32'(memReadEn), 32'd0);

      // Reset in the second cycle of a miss.
      @(negedge CLK);
      v = tbl[1];
      drive(v);
      @(negedge CLK);
      #2;
      check("premiss_stall", 32'(STALL), 32'd1);
      RESET = 1'b0;
      #1;
      check_reset_outputs("midmiss");
      @(negedge CLK);
      drive_idle();
      RESET = 1'b1;
      exp_cnt = 0;
      v = '{1'b1, 32'h700, 32'h0, 5'd13, 1'b1, 4'b1010, 3'b000, 32'h0BADF00D, 1, 4'b1010, 3'b000, 32'h0, 32'h0BADF00D, 1'b1, 1'b1, 1'b0};
      run_op(v);

      for (int i = 0; i < 200; i++) begin
         v.valid = $urandom_range(0, 7) != 0;
         kind = $urandom_range(0, 3);
         v.mr = {kind == 1 || kind == 3, f3s[$urandom_range(0, 4)]};
         v.mw = {kind >= 2, 2'($urandom_range(0, 2))};
         v.alu = $urandom;
         if ($urandom_range(0, 1) == 1) v.alu[1:0] = 2'b00;
         v.sdata = $urandom;
         v.rdata = $urandom;
         v.rd = 5'($urandom);
         v.we = $urandom_range(0, 1) == 1;
         v.busy = 0;
         fill_expect(v, r);
         r.busy = (r.e_ren[3] | r.e_wen[2]) ? $urandom_range(0, 5) : $urandom_range(0, 1);
         run_op(r);
      end

      @(negedge CLK);
      drive_idle();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
